exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset; ports: clk input 1 (rising-edge clock); resetn input 1 (async active-low reset).
REQ-002 SHALL have ds_to_es_valid input 1 (decode stage offers an instruction) and es_allowin output 1 (stage can accept this cycle).
REQ-003 SHALL have ds_alu_op input 19: one-hot op, same encoding as ALU, bits 15..18 = div/mod/divu/modu.
REQ-004 SHALL have ds_src1 input 32 and ds_src2 input 32 (operands), ds_dest input 5 (destination register) and ds_pc input 32.
REQ-005 SHALL have es_alu_op output 19, es_src1 output 32 and es_src2 output 32 (registered operands driven to ALU), and alu_result input 32 (combinational ALU return).
REQ-006 SHALL have es_to_ms_valid output 1 and ms_allowin input 1 (memory-stage handshake).
REQ-007 SHALL have es_result output 32, es_dest output 5 and es_pc output 32 (payload to memory stage, valid with es_to_ms_valid).

Function
REQ-008 SHALL compute es_allowin = !es_valid | (es_ready_go & ms_allowin), and es_to_ms_valid = es_valid & es_ready_go.
REQ-009 SHALL, when ds_to_es_valid & es_allowin, latch op, operands, dest and pc in one cycle and set es_valid; otherwise, when es_allowin, clear es_valid.
REQ-010 SHALL hold all latched fields stable while es_valid & !es_allowin (stall).
REQ-011 SHALL set es_ready_go = 1 for non-divide ops; es_result = alu_result, so latency is 1 cycle.
REQ-012 SHALL, for divide ops with DIV_ITER_EN defined, drive es_result from the divider and assert es_ready_go only in divider state DONE.
REQ-013 SHALL give the divider the FSM IDLE -> BUSY on es_valid & divide op & not yet started; BUSY runs exactly 32 cycles on a 6-bit counter; BUSY -> DONE; DONE -> IDLE when es_allowin.
REQ-014 SHALL implement the divider as restoring, on absolute values; quotient sign = src1 sign XOR src2 sign, remainder sign = src1 sign (signed ops only).
REQ-015 SHALL, on divide by zero, return quotient 0xFFFFFFFF and remainder = src1 with no exception; this applies to both signed and unsigned ops.
REQ-016 SHALL, on signed 0x80000000 / 0xFFFFFFFF, return quotient 0x80000000 and remainder 0.
REQ-017 SHALL make total divide latency from acceptance to es_to_ms_valid 34 cycles; a ms_allowin stall in DONE holds the result.
REQ-018 SHALL ensure a new instruction accepted in the same cycle DONE is left starts a fresh divide the following cycle, with no result reuse.

Reset
REQ-019 SHALL asynchronously clear on resetn low: es_valid=0, divider state=IDLE, counter=0, and all payload registers=0; thus es_to_ms_valid=0 and es_allowin=1.
REQ-020 SHALL abort an in-flight divide on reset mid-BUSY; the first post-reset instruction behaves as from power-up.

Configuration
REQ-021 SHALL honour macro EXE_DIV_ITER_EN (the DIV_ITER_EN of REQ-012): when defined, divide ops use the iterative divider per REQ-012..018.
REQ-022 SHALL, when EXE_DIV_ITER_EN is undefined, omit the divider entirely; divide ops then use alu_result with 1-cycle latency like all other ops.

Structure
REQ-023 SHALL place the ALU op bit-index constants, ALU_OP_W=19 and DIV_CYCLES=32 in shared package cpu_pkg.
REQ-024 SHALL put the divider in sub-module div_iter (start, signed_op, src1, src2 -> busy, done, quot, rem), instantiated only under EXE_DIV_ITER_EN.

Verification
REQ-025 SHALL cover: add 5+7 with ms_allowin=1 -> es_to_ms_valid next cycle, es_result=12, es_allowin stays 1.
REQ-026 SHALL cover: div signed -7/2 (macro on) -> es_to_ms_valid after 34 cycles with quotient 0xFFFFFFFD; mod returns 0xFFFFFFFF.
REQ-027 SHALL cover: divu 100/0 -> quotient 0xFFFFFFFF; modu 100/0 -> 100.
REQ-028 SHALL cover: div 0x80000000/0xFFFFFFFF -> 0x80000000; mod -> 0.
REQ-029 SHALL cover: ms_allowin=0 for 5 cycles in DONE -> result and es_dest held, es_allowin=0, then a single transfer occurs.
REQ-030 SHALL cover: resetn pulsed low at BUSY cycle 10 -> es_valid=0 immediately; next divu 9/3 -> 3 after 34 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared ALU op bit indices, widths and divider state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ALU_OP_W   = 19;
    localparam int DIV_CYCLES = 32;

    // One-hot ALU op bit positions
    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_SLT   = 2;
    localparam int ALU_SLTU  = 3;
    localparam int ALU_AND   = 4;
    localparam int ALU_NOR   = 5;
    localparam int ALU_OR    = 6;
    localparam int ALU_XOR   = 7;
    localparam int ALU_SLL   = 8;
    localparam int ALU_SRL   = 9;
    localparam int ALU_SRA   = 10;
    localparam int ALU_LUI   = 11;
    localparam int ALU_MUL   = 12;
    localparam int ALU_MULH  = 13;
    localparam int ALU_MULHU = 14;
    localparam int ALU_DIV   = 15;
    localparam int ALU_MOD   = 16;
    localparam int ALU_DIVU  = 17;
    localparam int ALU_MODU  = 18;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
        return |op[ALU_MODU:ALU_DIV];
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : 32-cycle restoring divider on magnitudes with sign fix-up.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        ack,
    input  logic        signed_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    localparam logic [5:0] c_last = 6'(DIV_CYCLES - 1);

    div_state_e  r_state;
    div_state_e  w_state_nxt;
    logic [5:0]  r_count;
    logic [31:0] r_quot;     // dividend shifts out the top while quotient bits enter the bottom
    logic [31:0] r_part;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_neg_r;

    logic [31:0] w_src1_abs;
    logic [31:0] w_src2_abs;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;

    assign w_src1_abs = (signed_op & src1[31]) ? (~src1 + 32'd1) : src1;
    assign w_src2_abs = (signed_op & src2[31]) ? (~src2 + 32'd1) : src2;
    assign w_shift    = {r_part, r_quot[31]};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_diff     = w_shift[31:0] - r_divisor;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: if (start) w_state_nxt = DIV_BUSY;
            DIV_BUSY: if (r_count == c_last) w_state_nxt = DIV_DONE;
            DIV_DONE: if (ack) w_state_nxt = DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
    end

    // A zero divisor yields all-ones quotient and |src1| remainder naturally;
    // suppressing the quotient negation and keeping the src1 sign on the
    // remainder then returns src1 unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count   <= 6'd0;
            r_quot    <= 32'd0;
            r_part    <= 32'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (r_state == DIV_IDLE && start) begin
            r_count   <= 6'd0;
            r_quot    <= w_src1_abs;
            r_part    <= 32'd0;
            r_divisor <= w_src2_abs;
            r_neg_q   <= signed_op & (src1[31] ^ src2[31]) & (src2 != 32'd0);
            r_neg_r   <= signed_op & src1[31];
        end else if (r_state == DIV_BUSY) begin
            r_count   <= r_count + 6'd1;
            r_quot    <= {r_quot[30:0], w_ge};
            r_part    <= w_ge ? w_diff : w_shift[31:0];
        end
    end

    assign busy = (r_state == DIV_BUSY);
    assign done = (r_state == DIV_DONE);
    assign quot = r_neg_q ? (~r_quot + 32'd1) : r_quot;
    assign rem  = r_neg_r ? (~r_part + 32'd1) : r_part;

endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage
// Brief    : Pipeline execute stage; iterative divider enabled by EXE_DIV_ITER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module exe_stage
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                ds_to_es_valid,
    output logic                es_allowin,
    input  logic [ALU_OP_W-1:0] ds_alu_op,
    input  logic [31:0]         ds_src1,
    input  logic [31:0]         ds_src2,
    input  logic [4:0]          ds_dest,
    input  logic [31:0]         ds_pc,
    output logic [ALU_OP_W-1:0] es_alu_op,
    output logic [31:0]         es_src1,
    output logic [31:0]         es_src2,
    input  logic [31:0]         alu_result,
    output logic                es_to_ms_valid,
    input  logic                ms_allowin,
    output logic [31:0]         es_result,
    output logic [4:0]          es_dest,
    output logic [31:0]         es_pc
);

    logic                r_es_valid;
    logic [ALU_OP_W-1:0] r_alu_op;
    logic [31:0]         r_src1;
    logic [31:0]         r_src2;
    logic [4:0]          r_dest;
    logic [31:0]         r_pc;
    logic                w_es_ready_go;

    assign es_allowin     = !r_es_valid | (w_es_ready_go & ms_allowin);
    assign es_to_ms_valid = r_es_valid & w_es_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_es_valid <= 1'b0;
        end else if (es_allowin) begin
            r_es_valid <= ds_to_es_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_alu_op <= '0;
            r_src1   <= 32'd0;
            r_src2   <= 32'd0;
            r_dest   <= 5'd0;
            r_pc     <= 32'd0;
        end else if (ds_to_es_valid && es_allowin) begin
            r_alu_op <= ds_alu_op;
            r_src1   <= ds_src1;
            r_src2   <= ds_src2;
            r_dest   <= ds_dest;
            r_pc     <= ds_pc;
        end
    end

    assign es_alu_op = r_alu_op;
    assign es_src1   = r_src1;
    assign es_src2   = r_src2;
    assign es_dest   = r_dest;
    assign es_pc     = r_pc;

`ifdef EXE_DIV_ITER_EN
    logic        w_is_div;
    logic        w_div_start;
    logic        w_div_busy;
    logic        w_div_done;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Idle divider with a valid divide op means this instruction has not started yet
    assign w_is_div    = is_div_op(r_alu_op);
    assign w_div_start = r_es_valid & w_is_div & !w_div_busy & !w_div_done;

    div_iter u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .start     (w_div_start),
        .ack       (es_allowin),
        .signed_op (r_alu_op[ALU_DIV] | r_alu_op[ALU_MOD]),
        .src1      (r_src1),
        .src2      (r_src2),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quot      (w_quot),
        .rem       (w_rem)
    );

    assign w_es_ready_go = !w_is_div | w_div_done;
    assign es_result     = !w_is_div ? alu_result
                         : (r_alu_op[ALU_MOD] | r_alu_op[ALU_MODU]) ? w_rem : w_quot;
`else
    assign w_es_ready_go = 1'b1;
    assign es_result     = alu_result;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_stage
// Brief    : Self-checking bench for exe_stage (honours EXE_DIV_ITER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_stage;
    import cpu_pkg::*;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                ds_to_es_valid = 1'b0;
    logic                es_allowin;
    logic [ALU_OP_W-1:0] ds_alu_op = '0;
    logic [31:0]         ds_src1 = 32'd0;
    logic [31:0]         ds_src2 = 32'd0;
    logic [4:0]          ds_dest = 5'd0;
    logic [31:0]         ds_pc = 32'd0;
    logic [ALU_OP_W-1:0] es_alu_op;
    logic [31:0]         es_src1;
    logic [31:0]         es_src2;
    logic [31:0]         alu_result;
    logic                es_to_ms_valid;
    logic                ms_allowin = 1'b1;
    logic [31:0]         es_result;
    logic [4:0]          es_dest;
    logic [31:0]         es_pc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .ds_to_es_valid (ds_to_es_valid),
        .es_allowin     (es_allowin),
        .ds_alu_op      (ds_alu_op),
        .ds_src1        (ds_src1),
        .ds_src2        (ds_src2),
        .ds_dest        (ds_dest),
        .ds_pc          (ds_pc),
        .es_alu_op      (es_alu_op),
        .es_src1        (es_src1),
        .es_src2        (es_src2),
        .alu_result     (alu_result),
        .es_to_ms_valid (es_to_ms_valid),
        .ms_allowin     (ms_allowin),
        .es_result      (es_result),
        .es_dest        (es_dest),
        .es_pc          (es_pc)
    );

    // Stand-in ALU; divide ops return a marker so the divider path is distinguishable
    function automatic logic [31:0] alu_model(input logic [ALU_OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        logic [63:0] up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        if (op[ALU_ADD])   return a + b;
        if (op[ALU_SUB])   return a - b;
        if (op[ALU_SLT])   return {31'd0, $signed(a) < $signed(b)};
        if (op[ALU_SLTU])  return {31'd0, a < b};
        if (op[ALU_AND])   return a & b;
        if (op[ALU_NOR])   return ~(a | b);
        if (op[ALU_OR])    return a | b;
        if (op[ALU_XOR])   return a ^ b;
        if (op[ALU_SLL])   return b << a[4:0];
        if (op[ALU_SRL])   return b >> a[4:0];
        if (op[ALU_SRA])   return 32'($signed(b) >>> a[4:0]);
        if (op[ALU_LUI])   return {b[15:0], 16'd0};
        if (op[ALU_MUL])   return up[31:0];
        if (op[ALU_MULH])  return sp[63:32];
        if (op[ALU_MULHU]) return up[63:32];
        if (is_div_op(op)) return a ^ b ^ 32'h5A5A_0F0F;
        return 32'd0;
    endfunction

    function automatic logic [31:0] ref_div(input logic [ALU_OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        logic want_rem;
        int sa;
        int sb;
        sgn      = op[ALU_DIV] | op[ALU_MOD];
        want_rem = op[ALU_MOD] | op[ALU_MODU];
        sa = a;
        sb = b;
        if (b == 32'd0) return want_rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_rem ? 32'd0 : 32'h8000_0000;
            return want_rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return want_rem ? (a % b) : (a / b);
    endfunction

    function automatic logic [31:0] exp_of(input logic [ALU_OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef EXE_DIV_ITER_EN
        if (is_div_op(op)) return ref_div(op, a, b);
`endif
        return alu_model(op, a, b);
    endfunction

    function automatic int lat_of(input logic [ALU_OP_W-1:0] op);
`ifdef EXE_DIV_ITER_EN
        if (is_div_op(op)) return 34;
`endif
        return 1;
    endfunction

    always_comb alu_result = alu_model(es_alu_op, es_src1, es_src2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Occupancy/latency model: one instruction in flight, ready a fixed latency after acceptance
    logic                m_occ = 1'b0;
    int                  m_ready = 0;
    logic [ALU_OP_W-1:0] m_op;
    logic [31:0]         m_a, m_b, m_res, m_pc;
    logic [4:0]          m_dest;

    always @(negedge clk) begin
        logic exp_v;
        logic exp_allow;
        cyc++;
        if (!resetn) begin
            m_occ = 1'b0;
        end else begin
            exp_v     = m_occ && (cyc >= m_ready);
            exp_allow = !m_occ || (exp_v && ms_allowin);
            check("es_to_ms_valid", 32'(es_to_ms_valid), 32'(exp_v));
            check("es_allowin", 32'(es_allowin), 32'(exp_allow));
            if (m_occ) begin
                check("es_alu_op", 32'(es_alu_op), 32'(m_op));
                check("es_src1", es_src1, m_a);
                check("es_src2", es_src2, m_b);
                check("es_dest", 32'(es_dest), 32'(m_dest));
                check("es_pc", es_pc, m_pc);
            end
            if (exp_v) check("es_result", es_result, m_res);
            if (exp_v && ms_allowin) m_occ = 1'b0;
            if (ds_to_es_valid && exp_allow) begin
                m_occ   = 1'b1;
                m_ready = cyc + lat_of(ds_alu_op);
                m_op    = ds_alu_op;
                m_a     = ds_src1;
                m_b     = ds_src2;
                m_dest  = ds_dest;
                m_pc    = ds_pc;
                m_res   = exp_of(ds_alu_op, ds_src1, ds_src2);
            end
        end
    end

    // Presents one instruction from posedge+1 and returns just after its acceptance edge
    task automatic issue(input int opbit, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        int n;
        ds_alu_op        = '0;
        ds_alu_op[opbit] = 1'b1;
        ds_src1 = a;
        ds_src2 = b;
        ds_dest = d;
        ds_pc   = pc_ctr;
        pc_ctr  = pc_ctr + 32'd4;
        ds_to_es_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!es_allowin && n < 200);
        if (!es_allowin) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: es_allowin got 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        ds_to_es_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!es_to_ms_valid && lat < 100);
    endtask

    task automatic run(input string name, input int opbit, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat);
        int lat;
        issue(opbit, a, b, 5'd3);
        wait_valid(lat);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, es_result, exp_res);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int xfers;
        int opbit;
        int sel;
        logic [ALU_OP_W-1:0] opv;
        logic [31:0] ra, rb;

        #1;
        check("reset_es_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
        check("reset_es_allowin", 32'(es_allowin), 32'd1);
        check("reset_es_dest", 32'(es_dest), 32'd0);
        check("reset_es_pc", es_pc, 32'd0);
        check("reset_es_alu_op", 32'(es_alu_op), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        issue(ALU_ADD, 32'd5, 32'd7, 5'd9);
        @(negedge clk);
        check("add_valid_next", 32'(es_to_ms_valid), 32'd1);
        check("add_result", es_result, 32'd12);
        check("add_allowin", 32'(es_allowin), 32'd1);
        @(posedge clk);
        #1;
        run("sub", ALU_SUB, 32'd3, 32'd10, 32'hFFFF_FFF9, 1);
        run("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);

`ifdef EXE_DIV_ITER_EN
        run("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run("mod_m7_2", ALU_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run("divu_100_0", ALU_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 34);
        run("modu_100_0", ALU_MODU, 32'd100, 32'd0, 32'd100, 34);
        run("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run("mod_ovf", ALU_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
        run("div_m9_0", ALU_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 34);
        run("mod_m9_0", ALU_MOD, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 34);
        run("divu_big", ALU_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 34);
`else
        run("div_bypass", ALU_DIV, 32'd100, 32'd3, 32'h5A5A_0F68, 1);
`endif

        // Output stall in the completion state
        ms_allowin = 1'b0;
        issue(ALU_DIVU, 32'd1000, 32'd10, 5'd7);
        wait_valid(lat);
        check("stall_latency", 32'(lat), 32'(lat_of(19'(1) << ALU_DIVU)));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_valid", 32'(es_to_ms_valid), 32'd1);
            check("stall_result", es_result, exp_of(19'(1) << ALU_DIVU, 32'd1000, 32'd10));
            check("stall_dest", 32'(es_dest), 32'd7);
            check("stall_allowin", 32'(es_allowin), 32'd0);
        end
        @(posedge clk);
        #1;
        ms_allowin = 1'b1;
        xfers = 0;
        repeat (3) begin
            @(negedge clk);
            if (es_to_ms_valid && ms_allowin) xfers++;
        end
        check("stall_single_transfer", 32'(xfers), 32'd1);
        @(posedge clk);
        #1;

        // Reset pulse partway through a divide
        issue(ALU_DIVU, 32'd1000, 32'd7, 5'd4);
        repeat (11) @(negedge clk);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("midreset_valid", 32'(es_to_ms_valid), 32'd0);
        check("midreset_allowin", 32'(es_allowin), 32'd1);
        check("midreset_dest", 32'(es_dest), 32'd0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run("post_reset_divu", ALU_DIVU, 32'd9, 32'd3, exp_of(19'(1) << ALU_DIVU, 32'd9, 32'd3),
            lat_of(19'(1) << ALU_DIVU));
`ifdef EXE_DIV_ITER_EN
        check("post_reset_literal", exp_of(19'(1) << ALU_DIVU, 32'd9, 32'd3), 32'd3);
`endif

        // Randomized traffic against the occupancy model
        for (int i = 0; i < 3000; i++) begin
            opbit = ($urandom_range(0, 4) == 0) ? int'($urandom_range(15, 18)) : int'($urandom_range(0, 14));
            opv        = '0;
            opv[opbit] = 1'b1;
            ra  = $urandom;
            rb  = $urandom;
            sel = int'($urandom_range(0, 7));
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if (sel == 2) begin
                ra = 32'($signed(ra) >>> 20);
                rb = 32'($signed(rb) >>> 27);
            end
            ds_alu_op      = opv;
            ds_src1        = ra;
            ds_src2        = rb;
            ds_dest        = 5'($urandom);
            ds_pc          = $urandom;
            ds_to_es_valid = ($urandom_range(0, 2) != 0);
            ms_allowin     = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        ds_to_es_valid = 1'b0;
        ms_allowin     = 1'b1;
        lat = 0;
        while (!es_allowin || es_to_ms_valid) begin
            @(negedge clk);
            lat++;
            if (lat > 100) break;
        end
        check("drain_idle", 32'(es_allowin && !es_to_ms_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
